sys_ctrl_boot_seq: RTL and testbench
====================================

SYS_CTRL_BOOT_SEQ -- requirements
Module: sys_ctrl_boot_seq

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 1024, max POLL_LOCK cycles per PLL before error.
REQ-002 SHALL have parameter RST_HOLD, default 16, cycles between clock-enable write and reset-release write.
REQ-003 SHALL have parameters ADDR_E_CLK_RST 12'h000, ADDR_P_CLK_RST 12'h004, ADDR_E_PLL 12'h020, ADDR_P_PLL 12'h024, all register offsets overridden at integration from sys_ctrl_pkg.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i input 1, system clock; arst_ni input 1, asynchronous active-low reset.
REQ-005 start_i  input  1  sequence start pulse.
REQ-006 en_p_core_i  input  1  also bring up the P core; sampled at start.
REQ-007 e_pll_cfg_i  input  16  E core PLL {fb_div[11:0], ref_div[3:0]}; sampled at start.
REQ-008 p_pll_cfg_i  input  16  P core PLL config; sampled at start.
REQ-009 busy_o  output  1  sequence in progress.
REQ-010 done_o  output  1  sticky success.
REQ-011 err_o  output  1  sticky failure.
REQ-012 err_code_o  output  3  1 write SLVERR, 2 lock timeout, 3 read SLVERR, 0 none.
REQ-013 mem_we_o / mem_waddr_o / mem_wdata_o / mem_wstrb_o  output  1/12/32/4  register-file write port.
REQ-014 mem_wresp_i  input  2  same-cycle write response; 00 OKAY.
REQ-015 mem_re_o / mem_raddr_o  output  1/12  register-file read port.
REQ-016 mem_rdata_i / mem_rresp_i  input  32/2  same-cycle read data/response.

Function
REQ-017 FSM states SHALL be IDLE, CFG_PLL, POLL_LOCK, CLK_EN, HOLD, RST_REL, DONE, ERROR; phase flag selects E (first) or P core.
REQ-018 IDLE/DONE/ERROR + start_i SHALL latch cfg inputs and en_p_core_i, clear done_o/err_o/err_code_o, select E phase, go CFG_PLL; start_i ignored in all other states.
REQ-019 CFG_PLL: one-cycle write, addr = phase PLL address, data {16'b0, cfg}; then POLL_LOCK.
REQ-020 POLL_LOCK: mem_re_o=1 every cycle at phase PLL address; rresp 00 and rdata[16]=1 -> CLK_EN; rresp!=00 -> ERROR code 3.
REQ-021 Timeout counter SHALL clear on entry to POLL_LOCK; LOCK_TIMEOUT reads without lock -> ERROR code 2 (lock on the final read wins).
REQ-022 CLK_EN: one-cycle write to phase CLK_RST address, data 32'h1 (clk_en=1, rst_n=0); then HOLD.
REQ-023 HOLD: exactly RST_HOLD cycles, no bus activity; then RST_REL.
REQ-024 RST_REL: one-cycle write data 32'h3; then CFG_PLL in P phase if E phase and latched en_p_core=1, else DONE.
REQ-025 Every write state SHALL check mem_wresp_i that cycle; !=00 -> ERROR code 1, no further writes.
REQ-026 mem_wstrb_o SHALL be 4'hF on writes; all mem outputs 0 when not asserted; never mem_we_o and mem_re_o together.
REQ-027 busy_o=1 in all states except IDLE, DONE, ERROR; done_o=1 only in DONE; err_o=1 only in ERROR.

Reset
REQ-028 arst_ni low SHALL force IDLE, all outputs 0, counters 0, latched cfg 0, immediately and asynchronously, including mid-sequence.
REQ-029 After reset release, no bus access until start_i.

Verification
REQ-030 E only, lock=1, start at cycle 0 -> cycle1 write 0x020 data cfg, cycle2 read, cycle3 write 0x000 data 1, cycle20 write 0x000 data 3, cycle21 done_o=1, busy_o=0.
REQ-031 en_p_core_i=1, lock=1 -> E sequence then P writes to 0x024/0x004 with same timing; done_o at cycle 41.
REQ-032 Lock never rises, LOCK_TIMEOUT=8 -> 8 reads cycles 2..9, cycle10 err_o=1, err_code_o=2, no CLK_EN write.
REQ-033 mem_wresp_i=10 on CLK_EN write -> next cycle err_code_o=1, no reset-release write.
REQ-034 arst_ni low during HOLD -> outputs 0 at once; new start_i after release restarts at CFG_PLL E.
REQ-035 start_i pulsed during POLL_LOCK -> ignored, sequence timing unchanged.

Source files
------------

// File: rtl/sys_ctrl_boot_seq.sv
// rtl/sys_ctrl_boot_seq.sv - PLL / clock-enable / reset-release boot sequencer for E and optional P core
module sys_ctrl_boot_seq #(
    parameter int          LOCK_TIMEOUT   = 1024,
    parameter int          RST_HOLD       = 16,
    parameter logic [11:0] ADDR_E_CLK_RST = 12'h000,
    parameter logic [11:0] ADDR_P_CLK_RST = 12'h004,
    parameter logic [11:0] ADDR_E_PLL     = 12'h020,
    parameter logic [11:0] ADDR_P_PLL     = 12'h024
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        start_i,
    input  logic        en_p_core_i,
    input  logic [15:0] e_pll_cfg_i,
    input  logic [15:0] p_pll_cfg_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_code_o,
    output logic        mem_we_o,
    output logic [11:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [1:0]  mem_wresp_i,
    output logic        mem_re_o,
    output logic [11:0] mem_raddr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  mem_rresp_i
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE, CFG_PLL, POLL_LOCK, CLK_EN, HOLD, RST_REL, DONE, ERROR
    } state_t;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic             en_p_q, en_p_d;
    logic [15:0]      e_cfg_q, e_cfg_d;
    logic [15:0]      p_cfg_q, p_cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;

    logic [11:0] pll_addr, clk_addr;
    logic [15:0] cfg_sel;
    logic        wr_ok;
    logic        unused_rdata;

    assign unused_rdata = ^{mem_rdata_i[31:17], mem_rdata_i[15:0]};

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            en_p_q  <= 1'b0;
            e_cfg_q <= '0;
            p_cfg_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            en_p_q  <= en_p_d;
            e_cfg_q <= e_cfg_d;
            p_cfg_q <= p_cfg_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // phase_q = 0 selects the E core, 1 the P core
    assign pll_addr = phase_q ? ADDR_P_PLL : ADDR_E_PLL;
    assign clk_addr = phase_q ? ADDR_P_CLK_RST : ADDR_E_CLK_RST;
    assign cfg_sel  = phase_q ? p_cfg_q : e_cfg_q;
    assign wr_ok    = (mem_wresp_i == 2'b00);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        en_p_d      = en_p_q;
        e_cfg_d     = e_cfg_q;
        p_cfg_d     = p_cfg_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        mem_we_o    = 1'b0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        mem_re_o    = 1'b0;
        mem_raddr_o = '0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    e_cfg_d = e_pll_cfg_i;
                    p_cfg_d = p_pll_cfg_i;
                    en_p_d  = en_p_core_i;
                    phase_d = 1'b0;
                    code_d  = 3'd0;
                    state_d = CFG_PLL;
                end
            end
            CFG_PLL: begin
                mem_we_o    = 1'b1;
                mem_waddr_o = pll_addr;
                mem_wdata_o = {16'b0, cfg_sel};
                cnt_d       = '0;
                if (!wr_ok) begin
                    code_d  = 3'd1;
                    state_d = ERROR;
                end else begin
                    state_d = POLL_LOCK;
                end
            end
            POLL_LOCK: begin
                mem_re_o    = 1'b1;
                mem_raddr_o = pll_addr;
                // a lock seen on the last permitted read still counts as success
                if (mem_rresp_i != 2'b00) begin
                    code_d  = 3'd3;
                    state_d = ERROR;
                end else if (mem_rdata_i[16]) begin
                    state_d = CLK_EN;
                end else if (cnt_q == LOCK_LAST) begin
                    code_d  = 3'd2;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLK_EN: begin
                mem_we_o    = 1'b1;
                mem_waddr_o = clk_addr;
                mem_wdata_o = 32'h1;
                cnt_d       = '0;
                if (!wr_ok) begin
                    code_d  = 3'd1;
                    state_d = ERROR;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RST_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RST_REL: begin
                mem_we_o    = 1'b1;
                mem_waddr_o = clk_addr;
                mem_wdata_o = 32'h3;
                if (!wr_ok) begin
                    code_d  = 3'd1;
                    state_d = ERROR;
                end else if (!phase_q && en_p_q) begin
                    phase_d = 1'b1;
                    state_d = CFG_PLL;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_wstrb_o = mem_we_o ? 4'hF : 4'h0;
    assign busy_o      = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERROR);
    assign err_code_o  = code_q;
endmodule

// File: tb/tb_sys_ctrl_boot_seq.sv
// tb/tb_sys_ctrl_boot_seq.sv - directed self-checking bench for sys_ctrl_boot_seq
module tb_sys_ctrl_boot_seq;
    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        en_p_core_i = 1'b0;
    logic [15:0] e_pll_cfg_i = '0;
    logic [15:0] p_pll_cfg_i = '0;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_code_o;
    logic        mem_we_o, mem_re_o;
    logic [11:0] mem_waddr_o, mem_raddr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    logic [1:0]  mem_wresp_i, mem_rresp_i;

    logic lock = 1'b1;
    logic werr_clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    assign mem_rdata_i = {15'b0, lock, 16'h0};
    assign mem_rresp_i = 2'b00;
    assign mem_wresp_i = (werr_clk && mem_we_o && mem_wdata_o == 32'h1) ? 2'b10 : 2'b00;

    sys_ctrl_boot_seq #(.LOCK_TIMEOUT(8)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .start_i(start_i), .en_p_core_i(en_p_core_i),
        .e_pll_cfg_i(e_pll_cfg_i), .p_pll_cfg_i(p_pll_cfg_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wresp_i(mem_wresp_i),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
        .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i)
    );

    wire [67:0] obs = {mem_we_o, mem_re_o, mem_waddr_o, mem_wdata_o, mem_wstrb_o,
                       mem_raddr_o, busy_o, done_o, err_o, err_code_o};

    function automatic logic [67:0] ev(input logic we, input logic re, input logic [11:0] wa,
                                       input logic [31:0] wd, input logic [11:0] ra,
                                       input logic busy, input logic done, input logic err,
                                       input logic [2:0] code);
        return {we, re, wa, wd, (we ? 4'hF : 4'h0), ra, busy, done, err, code};
    endfunction

    // expected bus/status for cycle k (1..20) of one core's bring-up
    function automatic logic [67:0] seq_exp(input int k, input logic [11:0] pll,
                                            input logic [11:0] clk, input logic [15:0] cfg);
        if (k == 1)       return ev(1, 0, pll, {16'b0, cfg}, 0, 1, 0, 0, 0);
        else if (k == 2)  return ev(0, 1, 0, 0, pll, 1, 0, 0, 0);
        else if (k == 3)  return ev(1, 0, clk, 32'h1, 0, 1, 0, 0, 0);
        else if (k == 20) return ev(1, 0, clk, 32'h3, 0, 1, 0, 0, 0);
        else              return ev(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_seq(input logic en_p, input logic [15:0] ec, input logic [15:0] pc);
        en_p_core_i = en_p;
        e_pll_cfg_i = ec;
        p_pll_cfg_i = pc;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        en_p_core_i = 1'b0;
        e_pll_cfg_i = '0;
        p_pll_cfg_i = '0;
    endtask

    task automatic test_reset();
        logic [67:0] exp;
        start_i = 1'b1;
        #12;
        exp = '0;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_hold got=%h exp=%h", obs, exp);
        end
        start_i = 1'b0;
        arst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, exp);
            end
        end
    endtask

    task automatic run_single(input string nm, input logic [15:0] cfg);
        logic [67:0] exp;
        for (int c = 1; c <= 21; c++) begin
            exp = (c < 21) ? seq_exp(c, 12'h020, 12'h000, cfg) : ev(0, 0, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_e_only();
        start_seq(1'b0, 16'hABC3, 16'h5555);
        run_single("e_only", 16'hABC3);
    endtask

    task automatic test_e_and_p();
        logic [67:0] exp;
        start_seq(1'b1, 16'h1234, 16'hBEEF);
        for (int c = 1; c <= 41; c++) begin
            if (c <= 20)      exp = seq_exp(c, 12'h020, 12'h000, 16'h1234);
            else if (c <= 40) exp = seq_exp(c - 20, 12'h024, 12'h004, 16'hBEEF);
            else              exp = ev(0, 0, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL e_and_p cyc=%0d got=%h exp=%h", c, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [67:0] exp;
        lock = 1'b0;
        start_seq(1'b1, 16'h0042, 16'h0043);
        for (int c = 1; c <= 12; c++) begin
            if (c == 1)      exp = seq_exp(1, 12'h020, 12'h000, 16'h0042);
            else if (c <= 9) exp = seq_exp(2, 12'h020, 12'h000, 16'h0042);
            else             exp = ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd2);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs, exp);
            end
            tick();
        end
        lock = 1'b1;
    endtask

    task automatic test_lock_last_read();
        logic [67:0] exp;
        lock = 1'b0;
        start_seq(1'b0, 16'h7771, 16'h0);
        for (int c = 1; c <= 28; c++) begin
            if (c == 1)       exp = seq_exp(1, 12'h020, 12'h000, 16'h7771);
            else if (c <= 9)  exp = seq_exp(2, 12'h020, 12'h000, 16'h7771);
            else if (c < 28)  exp = seq_exp(c - 7, 12'h020, 12'h000, 16'h7771);
            else              exp = ev(0, 0, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL lock_last cyc=%0d got=%h exp=%h", c, obs, exp);
            end
            if (c == 9) lock = 1'b1;
            tick();
        end
    endtask

    task automatic test_wresp_err();
        logic [67:0] exp;
        werr_clk = 1'b1;
        start_seq(1'b1, 16'h00A5, 16'h00B6);
        for (int c = 1; c <= 8; c++) begin
            exp = (c <= 3) ? seq_exp(c, 12'h020, 12'h000, 16'h00A5)
                           : ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd1);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL wresp_err cyc=%0d got=%h exp=%h", c, obs, exp);
            end
            tick();
        end
        werr_clk = 1'b0;
        start_seq(1'b0, 16'h3C3C, 16'h0);
        run_single("restart_after_err", 16'h3C3C);
    endtask

    task automatic test_reset_mid();
        logic [67:0] exp;
        exp = '0;
        start_seq(1'b1, 16'h1111, 16'h2222);
        for (int c = 1; c < 10; c++) tick();
        #2;
        arst_ni = 1'b0;
        #1;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_async got=%h exp=%h", obs, exp);
        end
        tick();
        arst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_quiet cyc=%0d got=%h exp=%h", c, obs, exp);
            end
        end
        start_seq(1'b0, 16'h9876, 16'h0);
        run_single("restart_after_rst", 16'h9876);
    endtask

    task automatic test_start_ignored();
        logic [67:0] exp;
        start_seq(1'b0, 16'h0F0F, 16'h0);
        for (int c = 1; c <= 22; c++) begin
            if (c <= 20) exp = seq_exp(c, 12'h020, 12'h000, 16'h0F0F);
            else         exp = ev(0, 0, 0, 0, 0, 0, 1, 0, 0);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL start_ignored cyc=%0d got=%h exp=%h", c, obs, exp);
            end
            if (c == 2) begin
                start_i = 1'b1;
                en_p_core_i = 1'b1;
                e_pll_cfg_i = 16'hFFFF;
                p_pll_cfg_i = 16'hEEEE;
            end else begin
                start_i = 1'b0;
                en_p_core_i = 1'b0;
                e_pll_cfg_i = '0;
                p_pll_cfg_i = '0;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_e_only();
        test_e_and_p();
        test_timeout();
        test_lock_last_read();
        test_wresp_err();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
